fft_peak_detect: RTL and testbench

Streaming spectrum analyser placed directly downstream of the 64-point FFT pipeline's natural-order reorder output. It consumes one complex bin per valid cycle (bin 0 first), computes |X|² per bin, and tracks the strongest bin and the total frame energy. At the end of each 64-bin frame it publishes the peak bin index, the peak magnitude and the energy, and pulses `frame_done`.

---
 rtl/fft_peak_detect.sv | 152 +++++++++++++++
 tb/tb_fft_peak_detect.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// fft_peak_detect
// Streaming spectrum analyser for the natural-order output of a 64-point FFT.
// Each accepted complex bin is squared and summed to |X|^2. A running search
// keeps the strongest bin and a running sum keeps the frame energy. At the end
// of every N-bin frame the results are published and frame_done pulses.
//
// Ports
//   clk          : single clock, rising edge
//   nrst         : asynchronous active-low reset
//   data_in      : bin value, re in [2*DW-1:DW], im in [DW-1:0], signed
//   in_valid     : data_in carries a bin this cycle
//   peak_bin     : index of the largest-magnitude bin of the last frame
//   peak_mag     : re^2+im^2 of that bin (unsigned)
//   frame_energy : sum of re^2+im^2 over all N bins of the last frame
//   frame_done   : one-cycle pulse, results updated on the same edge
module fft_peak_detect #(
    parameter int N       = 64,
    parameter int DW      = 16,
    parameter int SKIP_DC = 0
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [2*DW-1:0]              data_in,
    input  logic                         in_valid,
    output logic [$clog2(N)-1:0]         peak_bin,
    output logic [2*DW-1:0]              peak_mag,
    output logic [2*DW+$clog2(N)-1:0]    frame_energy,
    output logic                         frame_done
);

    localparam int LW = $clog2(N);
    localparam int EW = 2*DW + LW;
    localparam logic [LW-1:0] LAST_BIN  = LW'(N - 1);
    localparam logic [LW-1:0] FIRST_BIN = (SKIP_DC != 0) ? LW'(1) : '0;

    // Operands are sign-extended to the product width first so the squares
    // come out exact; the largest square (-2^(DW-1))^2 still fits.
    logic signed [DW-1:0]   reIn, imIn;
    logic signed [2*DW-1:0] reExt, imExt;

    assign reIn  = data_in[2*DW-1:DW];
    assign imIn  = data_in[DW-1:0];
    assign reExt = (2*DW)'(reIn);
    assign imExt = (2*DW)'(imIn);

    logic [LW-1:0]   cnt_q;
    logic            aValid_q;
    logic [LW-1:0]   aBin_q;
    logic [2*DW-1:0] reSq_q, imSq_q;
    logic            bValid_q;
    logic [LW-1:0]   bBin_q;
    logic [2*DW-1:0] mag_q;
    logic [2*DW-1:0] best_q, best_d;
    logic [LW-1:0]   bestBin_q, bestBin_d;
    logic [EW-1:0]   acc_q, acc_d;
    logic [LW-1:0]   peakBin_q;
    logic [2*DW-1:0] peakMag_q;
    logic [EW-1:0]   energy_q;
    logic            done_q;
    logic            publish;

    // Bin counter and stage A: squares are registered on the acceptance edge
    // together with the bin index they belong to.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q    <= '0;
            aValid_q <= 1'b0;
            aBin_q   <= '0;
            reSq_q   <= '0;
            imSq_q   <= '0;
        end else begin
            aValid_q <= in_valid;
            if (in_valid) begin
                cnt_q  <= cnt_q + LW'(1);
                aBin_q <= cnt_q;
                reSq_q <= reExt * reExt;
                imSq_q <= imExt * imExt;
            end
        end
    end

    // Stage B: magnitude. Valid bits advance every clock, so a bin already in
    // flight always completes regardless of what in_valid does afterwards.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bValid_q <= 1'b0;
            bBin_q   <= '0;
            mag_q    <= '0;
        end else begin
            bValid_q <= aValid_q;
            if (aValid_q) begin
                bBin_q <= aBin_q;
                mag_q  <= reSq_q + imSq_q;
            end
        end
    end

    // Stage C next state. Bin 0 restarts the energy sum and the first search
    // bin restarts the peak search, so a new frame can follow the last bin of
    // the previous one with no gap. Strict compare keeps the lowest index on
    // ties; with SKIP_DC the DC bin only contributes to energy.
    always_comb begin
        best_d    = best_q;
        bestBin_d = bestBin_q;
        acc_d     = acc_q;
        publish   = 1'b0;
        if (bValid_q) begin
            if (bBin_q == '0) begin
                acc_d = EW'(mag_q);
            end else begin
                acc_d = acc_q + EW'(mag_q);
            end
            if (!((SKIP_DC != 0) && (bBin_q == '0))) begin
                if ((bBin_q == FIRST_BIN) || (mag_q > best_q)) begin
                    best_d    = mag_q;
                    bestBin_d = bBin_q;
                end
            end
            publish = (bBin_q == LAST_BIN);
        end
    end

    // Stage C registers and the published results. Results are taken from the
    // next-state values so the last bin of the frame is included.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            best_q    <= '0;
            bestBin_q <= '0;
            acc_q     <= '0;
            peakBin_q <= '0;
            peakMag_q <= '0;
            energy_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            best_q    <= best_d;
            bestBin_q <= bestBin_d;
            acc_q     <= acc_d;
            done_q    <= publish;
            if (publish) begin
                peakBin_q <= bestBin_d;
                peakMag_q <= best_d;
                energy_q  <= acc_d;
            end
        end
    end

    assign peak_bin     = peakBin_q;
    assign peak_mag     = peakMag_q;
    assign frame_energy = energy_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect
// Drives two analysers, one searching all bins and one skipping DC, with the
// same bin stream. Frames are pushed as expected results into a queue the
// moment their last bin is accepted; a monitor pops and compares whenever
// frame_done is seen.
module tb_fft_peak_detect;

    localparam int N  = 64;
    localparam int DW = 16;

    logic          clk;
    logic          nrst;
    logic [31:0]   data_in;
    logic          in_valid;
    logic [5:0]    peakBin0, peakBin1;
    logic [31:0]   peakMag0, peakMag1;
    logic [37:0]   energy0, energy1;
    logic          done0, done1;

    typedef struct {
        longint t;
        longint bin0;
        longint mag0;
        longint bin1;
        longint mag1;
        longint energy;
    } expT;

    expT expQ[$];
    int  checks   = 0;
    int  failures = 0;

    logic signed [15:0] frRe [N];
    logic signed [15:0] frIm [N];

    fft_peak_detect #(.N(N), .DW(DW), .SKIP_DC(0)) dut0 (
        .clk(clk), .nrst(nrst), .data_in(data_in), .in_valid(in_valid),
        .peak_bin(peakBin0), .peak_mag(peakMag0), .frame_energy(energy0),
        .frame_done(done0)
    );

    fft_peak_detect #(.N(N), .DW(DW), .SKIP_DC(1)) dut1 (
        .clk(clk), .nrst(nrst), .data_in(data_in), .in_valid(in_valid),
        .peak_bin(peakBin1), .peak_mag(peakMag1), .frame_energy(energy1),
        .frame_done(done1)
    );

    // 10-unit clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard bound on simulation time.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: magnitudes straight from the definition, peak by linear scan
    // keeping the earliest maximum, energy as a plain sum.
    function automatic expT buildExp(input longint t);
        expT    e;
        longint mags [N];
        longint b0, b1;
        e.t = t;
        e.energy = 0;
        for (int k = 0; k < N; k++) begin
            longint r, i;
            r = longint'(frRe[k]);
            i = longint'(frIm[k]);
            mags[k] = r*r + i*i;
            e.energy += mags[k];
        end
        b0 = 0;
        for (int k = 1; k < N; k++) if (mags[k] > mags[b0]) b0 = k;
        b1 = 1;
        for (int k = 2; k < N; k++) if (mags[k] > mags[b1]) b1 = k;
        e.bin0 = b0;
        e.mag0 = mags[b0];
        e.bin1 = b1;
        e.mag1 = mags[b1];
        return e;
    endfunction

    task automatic idleCycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clearFrame();
        for (int k = 0; k < N; k++) begin
            frRe[k] = '0;
            frIm[k] = '0;
        end
    endtask

    // gapMode 0: contiguous; 1: toggle every cycle plus a 10-cycle hole
    // before bin 40; 2: random holes. nBins < N sends a partial frame.
    task automatic applyStimulus(input int gapMode, input int nBins);
        for (int k = 0; k < nBins; k++) begin
            if (gapMode == 1 && k == 40) repeat (10) idleCycle();
            data_in  = {frRe[k], frIm[k]};
            in_valid = 1'b1;
            @(posedge clk);
            if (k == N - 1) expQ.push_back(buildExp(longint'($time)));
            #1;
            in_valid = 1'b0;
            data_in  = $urandom;
            if (gapMode == 1) idleCycle();
            if (gapMode == 2 && $urandom_range(3) == 0) repeat ($urandom_range(1, 3)) idleCycle();
        end
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_bin0"}, longint'(peakBin0), 0);
        checkOutput({tag, "_mag0"}, longint'(peakMag0), 0);
        checkOutput({tag, "_energy0"}, longint'(energy0), 0);
        checkOutput({tag, "_done0"}, longint'(done0), 0);
        checkOutput({tag, "_bin1"}, longint'(peakBin1), 0);
        checkOutput({tag, "_done1"}, longint'(done1), 0);
    endtask

    // Monitor: every frame_done must match the oldest outstanding frame and
    // arrive at the negedge 2.5 cycles after its last bin's acceptance edge.
    always @(negedge clk) begin
        if (done0 || done1) begin
            checkOutput("done0_high", longint'(done0), 1);
            checkOutput("done1_high", longint'(done1), 1);
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0 at t=%0t", $time);
            end else begin
                expT e;
                e = expQ.pop_front();
                checkOutput("done_time", longint'($time), e.t + 25);
                checkOutput("peak_bin0", longint'(peakBin0), e.bin0);
                checkOutput("peak_mag0", longint'(peakMag0), e.mag0);
                checkOutput("energy0", longint'(energy0), e.energy);
                checkOutput("peak_bin1", longint'(peakBin1), e.bin1);
                checkOutput("peak_mag1", longint'(peakMag1), e.mag1);
                checkOutput("energy1", longint'(energy1), e.energy);
            end
        end
    end

    initial begin
        nrst     = 1'b0;
        in_valid = 1'b1;
        data_in  = $urandom;

        // Reset held with traffic present: everything stays at zero.
        repeat (4) begin
            @(negedge clk);
            checkZeroOutputs("reset");
            data_in = $urandom;
        end
        in_valid = 1'b0;
        nrst     = 1'b1;
        @(posedge clk);
        #1;

        // Single tone at bin 5.
        clearFrame();
        frRe[5] = 16'sh0800;
        applyStimulus(0, N);
        repeat (4) idleCycle();
        checkOutput("tone_bin_const", longint'(peakBin0), 5);
        checkOutput("tone_mag_const", longint'(peakMag0), 64'h40_0000);
        checkOutput("tone_energy_const", longint'(energy0), 64'h40_0000);

        // Tie at bins 3 and 10, then full scale, back-to-back.
        clearFrame();
        frRe[3] = 16'sd100;  frIm[3] = -16'sd100;
        frRe[10] = 16'sd100; frIm[10] = -16'sd100;
        applyStimulus(0, N);
        for (int k = 0; k < N; k++) begin
            frRe[k] = 16'sh8000;
            frIm[k] = 16'sh8000;
        end
        applyStimulus(0, N);
        repeat (4) idleCycle();
        checkOutput("full_energy_const", longint'(energy0), 64'h20_0000_0000);

        // Large DC bin and a tiny last bin.
        clearFrame();
        frRe[0]  = 16'sh7FFF;
        frRe[63] = 16'sd1;
        applyStimulus(0, N);
        repeat (4) idleCycle();
        checkOutput("skipdc_bin_const", longint'(peakBin1), 63);
        checkOutput("skipdc_energy_const", longint'(energy1), 64'h3FFF_0002);

        // Tone again with gaps.
        clearFrame();
        frRe[5] = 16'sh0800;
        applyStimulus(1, N);
        repeat (5) idleCycle();

        // Reset partway through a frame: nothing published, outputs cleared.
        applyStimulus(0, 30);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        checkZeroOutputs("midreset");
        nrst = 1'b1;
        repeat (3) idleCycle();
        checkZeroOutputs("postreset");
        applyStimulus(0, N);
        repeat (4) idleCycle();
        checkOutput("after_reset_bin_const", longint'(peakBin0), 5);

        // Random frames, some with ties from a tiny value set, random gaps.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < N; k++) begin
                if (f % 3 == 0) begin
                    frRe[k] = 16'($signed($urandom_range(0, 4)) - 2);
                    frIm[k] = 16'($signed($urandom_range(0, 4)) - 2);
                end else begin
                    frRe[k] = 16'($urandom);
                    frIm[k] = 16'($urandom);
                end
            end
            applyStimulus((f % 2 == 0) ? 2 : 0, N);
        end

        repeat (10) idleCycle();
        checkOutput("queue_empty", longint'(expQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
